// File: rtl/wb_write_arbiter_if.sv
`default_nettype none
// wb_write_arbiter_if -- ALU, load-return, pending-scoreboard and register-file write-port bundle (rev 1.0)
interface wb_write_arbiter_if #(
  parameter int NUM_REG   = 8,
  parameter int SEL_WIDTH = 3,
  parameter int D_WIDTH   = 34
);
  logic                 alu_valid_i;
  logic [SEL_WIDTH-1:0] alu_wa_i;
  logic [D_WIDTH-1:0]   alu_wd_i;
  logic                 alu_stall_o;
  logic                 mem_valid_i;
  logic                 mem_ready_o;
  logic [SEL_WIDTH-1:0] mem_wa_i;
  logic [D_WIDTH-1:0]   mem_wd_i;
  logic                 pend_set_i;
  logic [SEL_WIDTH-1:0] pend_reg_i;
  logic [NUM_REG-1:0]   pending_o;
  logic                 write_enable_o;
  logic [SEL_WIDTH-1:0] write_reg_o;
  logic [D_WIDTH-1:0]   write_data_o;

  modport slave (
    input  alu_valid_i, alu_wa_i, alu_wd_i,
    output alu_stall_o,
    input  mem_valid_i, mem_wa_i, mem_wd_i,
    output mem_ready_o,
    input  pend_set_i, pend_reg_i,
    output pending_o, write_enable_o, write_reg_o, write_data_o
  );

  modport master (
    output alu_valid_i, alu_wa_i, alu_wd_i,
    input  alu_stall_o,
    output mem_valid_i, mem_wa_i, mem_wd_i,
    input  mem_ready_o,
    output pend_set_i, pend_reg_i,
    input  pending_o, write_enable_o, write_reg_o, write_data_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// wb_write_arbiter -- merges ALU and buffered load results onto the register-file write port (rev 1.0)
module wb_write_arbiter #(
  parameter int NUM_REG    = 8,
  parameter int SEL_WIDTH  = 3,
  parameter int D_WIDTH    = 34,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n_i,
  wb_write_arbiter_if.slave bus
);
  localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
  localparam logic [ST_W-1:0]  STARVE_LIM = ST_W'(STARVE_MAX);

  logic [SEL_WIDTH-1:0] fifo_wa [DEPTH];
  logic [D_WIDTH-1:0]   fifo_wd [DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     count;
  logic [ST_W-1:0]      starve_cnt;
  logic [NUM_REG-1:0]   pending;
  logic [NUM_REG-1:0]   pend_next;
  logic                 we;
  logic [SEL_WIDTH-1:0] wreg;
  logic [D_WIDTH-1:0]   wdata;

  logic                 empty;
  logic                 full;
  logic                 force_fifo;
  logic                 grant_alu;
  logic                 grant_fifo;
  logic                 push;
  logic [SEL_WIDTH-1:0] head_wa;
  logic [D_WIDTH-1:0]   head_wd;

  assign empty      = (count == '0);
  assign full       = (count == DEPTH_CNT);
  assign force_fifo = !empty && (starve_cnt == STARVE_LIM);
  assign grant_alu  = bus.alu_valid_i && !force_fifo;
  assign grant_fifo = !grant_alu && !empty;
  assign push       = bus.mem_valid_i && !full;
  assign head_wa    = fifo_wa[rd_ptr];
  assign head_wd    = fifo_wd[rd_ptr];

  assign bus.alu_stall_o    = bus.alu_valid_i && force_fifo;
  assign bus.mem_ready_o    = !full;
  assign bus.pending_o      = pending;
  assign bus.write_enable_o = we;
  assign bus.write_reg_o    = wreg;
  assign bus.write_data_o   = wdata;

  // Storage needs no reset: pointers and count alone define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wa[wr_ptr] <= bus.mem_wa_i;
      fifo_wd[wr_ptr] <= bus.mem_wd_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)       wr_ptr <= wr_ptr + PTR_W'(1);
      if (grant_fifo) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, grant_fifo})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      starve_cnt <= '0;
    end else if (empty || grant_fifo) begin
      starve_cnt <= '0;
    end else if (grant_alu && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + ST_W'(1);
    end
  end

  // A new load issue to a register outranks the retirement of an older load to it.
  always_comb begin
    pend_next = pending;
    for (int r = 0; r < NUM_REG; r++) begin
      if (bus.pend_set_i && (bus.pend_reg_i == SEL_WIDTH'(r))) begin
        pend_next[r] = 1'b1;
      end else if (grant_fifo && (head_wa == SEL_WIDTH'(r))) begin
        pend_next[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      pending <= '0;
      we      <= 1'b0;
      wreg    <= '0;
      wdata   <= '0;
    end else begin
      pending <= pend_next;
      we      <= grant_alu || grant_fifo;
      if (grant_alu) begin
        wreg  <= bus.alu_wa_i;
        wdata <= bus.alu_wd_i;
      end else if (grant_fifo) begin
        wreg  <= head_wa;
        wdata <= head_wd;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// tb_wb_write_arbiter -- directed self-checking bench for wb_write_arbiter (rev 1.0)
module tb_wb_write_arbiter;
  localparam int NUM_REG    = 8;
  localparam int SEL_WIDTH  = 3;
  localparam int D_WIDTH    = 34;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 3;

  logic clk = 1'b0;
  logic rst_n_i;
  int   errors = 0;
  int   checks = 0;

  wb_write_arbiter_if #(.NUM_REG(NUM_REG), .SEL_WIDTH(SEL_WIDTH), .D_WIDTH(D_WIDTH)) bus ();

  wb_write_arbiter #(
    .NUM_REG(NUM_REG), .SEL_WIDTH(SEL_WIDTH), .D_WIDTH(D_WIDTH),
    .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst_n_i(rst_n_i),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.alu_valid_i = 1'b0;
    bus.alu_wa_i    = '0;
    bus.alu_wd_i    = '0;
    bus.mem_valid_i = 1'b0;
    bus.mem_wa_i    = '0;
    bus.mem_wd_i    = '0;
    bus.pend_set_i  = 1'b0;
    bus.pend_reg_i  = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset;
    idle_inputs();
    bus.alu_valid_i = 1'b1; bus.alu_wa_i = 3'd7; bus.alu_wd_i = 34'h3_FFFF_FFFF;
    bus.mem_valid_i = 1'b1; bus.mem_wa_i = 3'd6; bus.mem_wd_i = 34'h1_2345_6789;
    bus.pend_set_i  = 1'b1; bus.pend_reg_i = 3'd5;
    rst_n_i = 1'b0;
    tick();
    checks++; if (bus.write_enable_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", bus.write_enable_o); end
    checks++; if (bus.write_reg_o !== 3'd0) begin errors++; $display("FAIL reset_reg: got %0d want 0", bus.write_reg_o); end
    checks++; if (bus.write_data_o !== 34'h0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.write_data_o); end
    checks++; if (bus.pending_o !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h want 00", bus.pending_o); end
    checks++; if (bus.mem_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", bus.mem_ready_o); end
    rst_n_i = 1'b1;
    idle_inputs();
    tick();
    checks++; if (bus.write_enable_o !== 1'b0) begin errors++; $display("FAIL reset_no_enqueue: got we=%0b want 0", bus.write_enable_o); end
  endtask

  task automatic test_alu;
    do_reset();
    bus.alu_valid_i = 1'b1; bus.alu_wa_i = 3'd5; bus.alu_wd_i = 34'h2_0000_0001;
    #1;
    checks++; if (bus.alu_stall_o !== 1'b0) begin errors++; $display("FAIL alu_stall: got %0b want 0", bus.alu_stall_o); end
    tick();
    idle_inputs();
    checks++; if (bus.write_enable_o !== 1'b1) begin errors++; $display("FAIL alu_we: got %0b want 1", bus.write_enable_o); end
    checks++; if (bus.write_reg_o !== 3'd5) begin errors++; $display("FAIL alu_reg: got %0d want 5", bus.write_reg_o); end
    checks++; if (bus.write_data_o !== 34'h2_0000_0001) begin errors++; $display("FAIL alu_data: got %h want 200000001", bus.write_data_o); end
    tick();
    checks++; if (bus.write_enable_o !== 1'b0) begin errors++; $display("FAIL alu_idle_we: got %0b want 0", bus.write_enable_o); end
    checks++; if (bus.write_reg_o !== 3'd5) begin errors++; $display("FAIL alu_hold_reg: got %0d want 5", bus.write_reg_o); end
    checks++; if (bus.write_data_o !== 34'h2_0000_0001) begin errors++; $display("FAIL alu_hold_data: got %h want 200000001", bus.write_data_o); end
  endtask

  task automatic test_load;
    do_reset();
    bus.pend_set_i = 1'b1; bus.pend_reg_i = 3'd3;
    tick();
    idle_inputs();
    checks++; if (bus.pending_o !== 8'h08) begin errors++; $display("FAIL load_pend_set: got %h want 08", bus.pending_o); end
    tick();
    bus.mem_valid_i = 1'b1; bus.mem_wa_i = 3'd3; bus.mem_wd_i = 34'h1234;
    #1;
    checks++; if (bus.mem_ready_o !== 1'b1) begin errors++; $display("FAIL load_ready: got %0b want 1", bus.mem_ready_o); end
    tick();
    idle_inputs();
    checks++; if (bus.write_enable_o !== 1'b0) begin errors++; $display("FAIL load_no_fallthrough: got we=%0b want 0", bus.write_enable_o); end
    checks++; if (bus.pending_o !== 8'h08) begin errors++; $display("FAIL load_pend_hold: got %h want 08", bus.pending_o); end
    tick();
    checks++; if (bus.write_enable_o !== 1'b1) begin errors++; $display("FAIL load_we: got %0b want 1", bus.write_enable_o); end
    checks++; if (bus.write_reg_o !== 3'd3) begin errors++; $display("FAIL load_reg: got %0d want 3", bus.write_reg_o); end
    checks++; if (bus.write_data_o !== 34'h1234) begin errors++; $display("FAIL load_data: got %h want 1234", bus.write_data_o); end
    checks++; if (bus.pending_o !== 8'h00) begin errors++; $display("FAIL load_pend_clear: got %h want 00", bus.pending_o); end
  endtask

  task automatic test_fifo_fill;
    int alu_idx   [13] = '{0, 1, 2, 3, 4, 4, 5, 6, 7, 7, 8, 9, 10};
    bit mem_vld   [13] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    int mem_idx   [13] = '{0, 1, 2, 3, 4, 4, 0, 0, 0, 0, 0, 0, 0};
    bit exp_stall [13] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    bit exp_ready [13] = '{1, 1, 1, 1, 0, 1, 0, 0, 0, 1, 1, 1, 1};
    bit exp_load  [13] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    int exp_idx   [13] = '{0, 1, 2, 3, 0, 4, 5, 6, 1, 7, 8, 9, 2};
    logic [SEL_WIDTH-1:0] ewa;
    logic [D_WIDTH-1:0]   ewd;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      bus.alu_valid_i = 1'b1;
      bus.alu_wa_i    = 3'd6;
      bus.alu_wd_i    = 34'h2_0000_0A00 + D_WIDTH'(alu_idx[c]);
      bus.mem_valid_i = mem_vld[c];
      bus.mem_wa_i    = SEL_WIDTH'(mem_idx[c] + 1);
      bus.mem_wd_i    = 34'h1_0000_0100 + D_WIDTH'(mem_idx[c]);
      #1;
      checks++; if (bus.alu_stall_o !== exp_stall[c]) begin errors++; $display("FAIL fill_stall c%0d: got %0b want %0b", c, bus.alu_stall_o, exp_stall[c]); end
      checks++; if (bus.mem_ready_o !== exp_ready[c]) begin errors++; $display("FAIL fill_ready c%0d: got %0b want %0b", c, bus.mem_ready_o, exp_ready[c]); end
      tick();
      ewa = exp_load[c] ? SEL_WIDTH'(exp_idx[c] + 1) : 3'd6;
      ewd = exp_load[c] ? 34'h1_0000_0100 + D_WIDTH'(exp_idx[c]) : 34'h2_0000_0A00 + D_WIDTH'(exp_idx[c]);
      checks++; if (bus.write_enable_o !== 1'b1) begin errors++; $display("FAIL fill_we c%0d: got %0b want 1", c, bus.write_enable_o); end
      checks++; if (bus.write_reg_o !== ewa) begin errors++; $display("FAIL fill_reg c%0d: got %0d want %0d", c, bus.write_reg_o, ewa); end
      checks++; if (bus.write_data_o !== ewd) begin errors++; $display("FAIL fill_data c%0d: got %h want %h", c, bus.write_data_o, ewd); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      bus.alu_valid_i = 1'b1; bus.alu_wa_i = 3'd6; bus.alu_wd_i = 34'h0_0000_00A0 + D_WIDTH'(c);
      bus.mem_valid_i = 1'b1; bus.mem_wa_i = SEL_WIDTH'(c + 1); bus.mem_wd_i = 34'h3_0000_0000 + D_WIDTH'(c);
      bus.pend_set_i  = (c == 0); bus.pend_reg_i = 3'd4;
      tick();
    end
    bus.pend_set_i = 1'b1; bus.pend_reg_i = 3'd1;
    rst_n_i = 1'b0;
    tick();
    checks++; if (bus.write_enable_o !== 1'b0) begin errors++; $display("FAIL mid_we: got %0b want 0", bus.write_enable_o); end
    checks++; if (bus.write_reg_o !== 3'd0) begin errors++; $display("FAIL mid_reg: got %0d want 0", bus.write_reg_o); end
    checks++; if (bus.write_data_o !== 34'h0) begin errors++; $display("FAIL mid_data: got %h want 0", bus.write_data_o); end
    checks++; if (bus.pending_o !== 8'h00) begin errors++; $display("FAIL mid_pending: got %h want 00", bus.pending_o); end
    checks++; if (bus.mem_ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready: got %0b want 1", bus.mem_ready_o); end
    rst_n_i = 1'b1;
    idle_inputs();
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (bus.write_enable_o !== 1'b0) begin errors++; $display("FAIL mid_stale c%0d: got we=%0b want 0", c, bus.write_enable_o); end
    end
  endtask

  task automatic test_scoreboard;
    do_reset();
    bus.pend_set_i = 1'b1; bus.pend_reg_i = 3'd2;
    bus.mem_valid_i = 1'b1; bus.mem_wa_i = 3'd2; bus.mem_wd_i = 34'h55;
    tick();
    bus.mem_valid_i = 1'b0;
    tick();
    bus.pend_set_i = 1'b0;
    checks++; if (bus.write_enable_o !== 1'b1 || bus.write_reg_o !== 3'd2) begin errors++; $display("FAIL sb_write: got we=%0b reg=%0d want 1/2", bus.write_enable_o, bus.write_reg_o); end
    checks++; if (bus.pending_o !== 8'h04) begin errors++; $display("FAIL sb_set_wins: got %h want 04", bus.pending_o); end
    bus.pend_set_i = 1'b1; bus.pend_reg_i = 3'd4;
    tick();
    bus.pend_set_i = 1'b0;
    bus.alu_valid_i = 1'b1; bus.alu_wa_i = 3'd4; bus.alu_wd_i = 34'h0;
    tick();
    checks++; if (bus.pending_o !== 8'h14) begin errors++; $display("FAIL sb_alu_no_clear: got %h want 14", bus.pending_o); end
    bus.alu_wa_i = 3'd0; bus.alu_wd_i = 34'h3_FFFF_FFFF;
    tick();
    bus.alu_valid_i = 1'b0;
    checks++; if (bus.write_reg_o !== 3'd0) begin errors++; $display("FAIL sb_reg0_addr: got %0d want 0", bus.write_reg_o); end
    checks++; if (bus.write_data_o !== 34'h3_FFFF_FFFF) begin errors++; $display("FAIL sb_reg0_data: got %h want 3ffffffff", bus.write_data_o); end
    bus.mem_valid_i = 1'b1; bus.mem_wa_i = 3'd2; bus.mem_wd_i = 34'h66;
    tick();
    bus.mem_valid_i = 1'b0;
    tick();
    checks++; if (bus.pending_o !== 8'h10) begin errors++; $display("FAIL sb_load_clear: got %h want 10", bus.pending_o); end
  endtask

  task automatic test_wrap;
    logic [SEL_WIDTH-1:0] ewa;
    logic [D_WIDTH-1:0]   ewd;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      bus.mem_valid_i = (c < 10);
      bus.mem_wa_i    = SEL_WIDTH'(c % 8);
      bus.mem_wd_i    = 34'h3_0000_0000 + D_WIDTH'(c * 32'h111);
      #1;
      checks++; if (bus.mem_ready_o !== 1'b1) begin errors++; $display("FAIL wrap_ready c%0d: got %0b want 1", c, bus.mem_ready_o); end
      tick();
      if (c >= 1 && c <= 10) begin
        ewa = SEL_WIDTH'((c - 1) % 8);
        ewd = 34'h3_0000_0000 + D_WIDTH'((c - 1) * 32'h111);
        checks++; if (bus.write_enable_o !== 1'b1) begin errors++; $display("FAIL wrap_we c%0d: got %0b want 1", c, bus.write_enable_o); end
        checks++; if (bus.write_reg_o !== ewa) begin errors++; $display("FAIL wrap_reg c%0d: got %0d want %0d", c, bus.write_reg_o, ewa); end
        checks++; if (bus.write_data_o !== ewd) begin errors++; $display("FAIL wrap_data c%0d: got %h want %h", c, bus.write_data_o, ewd); end
      end else begin
        checks++; if (bus.write_enable_o !== 1'b0) begin errors++; $display("FAIL wrap_idle c%0d: got %0b want 0", c, bus.write_enable_o); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst_n_i = 1'b0;
    idle_inputs();
    tick();
    test_reset();
    test_alu();
    test_load();
    test_fifo_fill();
    test_reset_mid();
    test_scoreboard();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
